// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM (slave side) and the
// datapath/memory (master side).
interface multicycle_control_fsm_if;
  logic [5:0] Opcode;
  logic       MemReady;
  logic [2:0] ALUOp;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [3:0] State;
  logic       Illegal;

  modport slave (
    input  Opcode, MemReady,
    output ALUOp, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, State, Illegal
  );

  modport master (
    output Opcode, MemReady,
    input  ALUOp, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, State, Illegal
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style control FSM. Strobes are registered from the next state,
// so they line up with State; only the FETCH MemReady qualification and the
// DECODE illegal-opcode pulse look at live inputs.
module multicycle_control_fsm (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.slave  ctrl_if
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_RWB    = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_IEXEC  = 4'd11,
    S_IWB    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
  } ctrl_t;

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] alu;
    case (op)
      OP_ANDI: alu = 3'b011;
      OP_ORI:  alu = 3'b100;
      OP_SLTI: alu = 3'b101;
      default: alu = 3'b000;
    endcase
    return alu;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  // FETCH's IRWrite and MemReady-dependent PCWrite are added outside this table.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b010;
      end
      S_RWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 3'b001;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = imm_alu_op(op);
      end
      S_IWB:   c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     r_state;
  logic [5:0] r_opcode;
  ctrl_t      r_ctrl;

  state_t     w_next;
  logic [5:0] w_opcode_next;
  logic       w_fetch_ready;

  // Next-state selection and the opcode value that will be latched this edge.
  always_comb begin
    w_next        = S_IDLE;
    w_opcode_next = r_opcode;
    if (r_state == S_DECODE) begin
      w_opcode_next = ctrl_if.Opcode;
    end else begin
      w_opcode_next = r_opcode;
    end
    case (r_state)
      S_IDLE:  w_next = S_FETCH;
      S_FETCH: w_next = ctrl_if.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctrl_if.Opcode)
          OP_LW, OP_SW:                       w_next = S_MEMADR;
          OP_RTYPE:                           w_next = S_EXEC;
          OP_BEQ:                             w_next = S_BRANCH;
          OP_J:                               w_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  w_next = S_IEXEC;
          default:                            w_next = S_FETCH;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything but sw means a load.
      S_MEMADR: w_next = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = ctrl_if.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = ctrl_if.MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_IEXEC:  w_next = S_IWB;
      S_IWB:    w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  // State, latched opcode and registered strobes; reset clears all at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_opcode <= 6'b000000;
      r_ctrl   <= '0;
    end else begin
      r_state  <= w_next;
      r_opcode <= w_opcode_next;
      r_ctrl   <= decode_ctrl(w_next, w_opcode_next);
    end
  end

  assign w_fetch_ready = (r_state == S_FETCH) & ctrl_if.MemReady;

  assign ctrl_if.ALUOp       = r_ctrl.alu_op;
  assign ctrl_if.ALUSrcB     = r_ctrl.alu_src_b;
  assign ctrl_if.PCSource    = r_ctrl.pc_source;
  assign ctrl_if.PCWrite     = r_ctrl.pc_write | w_fetch_ready;
  assign ctrl_if.PCWriteCond = r_ctrl.pc_write_cond;
  assign ctrl_if.IorD        = r_ctrl.i_or_d;
  assign ctrl_if.MemRead     = r_ctrl.mem_read;
  assign ctrl_if.MemWrite    = r_ctrl.mem_write;
  assign ctrl_if.IRWrite     = w_fetch_ready;
  assign ctrl_if.MemtoReg    = r_ctrl.mem_to_reg;
  assign ctrl_if.RegDst      = r_ctrl.reg_dst;
  assign ctrl_if.RegWrite    = r_ctrl.reg_write;
  assign ctrl_if.ALUSrcA     = r_ctrl.alu_src_a;
  assign ctrl_if.State       = r_state;
  assign ctrl_if.Illegal     = (r_state == S_DECODE) & ~is_legal(ctrl_if.Opcode);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each driven cycle pushes the expected control vector, which
// is popped and compared against the DUT outputs 1ns after the inputs settle.
module tb_multicycle_control_fsm;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [5:0] tb_lat;

  typedef struct {
    string       tag;
    logic [21:0] v;
  } sb_t;
  sb_t sb_q[$];

  multicycle_control_fsm_if u_if ();

  multicycle_control_fsm dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {State, ALUOp, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD, MemRead,
  //  MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal}
  logic [21:0] w_obs;
  assign w_obs = {u_if.State, u_if.ALUOp, u_if.ALUSrcB, u_if.PCSource,
                  u_if.PCWrite, u_if.PCWriteCond, u_if.IorD, u_if.MemRead,
                  u_if.MemWrite, u_if.IRWrite, u_if.MemtoReg, u_if.RegDst,
                  u_if.RegWrite, u_if.ALUSrcA, u_if.Illegal};

  function automatic logic tb_legal(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd2) || (op == 6'd4) || (op == 6'd8) ||
           (op == 6'd10) || (op == 6'd12) || (op == 6'd13) ||
           (op == 6'd35) || (op == 6'd43);
  endfunction

  function automatic logic [21:0] model(input logic [3:0] s, input logic [5:0] lat,
                                        input logic [5:0] op, input logic mr);
    logic [2:0] aluop; logic [1:0] srcb, pcs;
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
    {aluop, srcb, pcs} = 7'd0;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = 11'd0;
    case (s)
      4'd1:  begin mrd = 1'b1; srcb = 2'b01; pcw = mr; irw = mr; end
      4'd2:  begin srcb = 2'b11; ill = !tb_legal(op); end
      4'd3:  begin srca = 1'b1; srcb = 2'b10; end
      4'd4:  begin mrd = 1'b1; iord = 1'b1; end
      4'd5:  begin m2r = 1'b1; rw = 1'b1; end
      4'd6:  begin mwr = 1'b1; iord = 1'b1; end
      4'd7:  begin srca = 1'b1; aluop = 3'b010; end
      4'd8:  begin rdst = 1'b1; rw = 1'b1; end
      4'd9:  begin srca = 1'b1; aluop = 3'b001; pcwc = 1'b1; pcs = 2'b01; end
      4'd10: begin pcw = 1'b1; pcs = 2'b10; end
      4'd11: begin
        srca = 1'b1; srcb = 2'b10;
        aluop = (lat == 6'b001100) ? 3'b011 :
                (lat == 6'b001101) ? 3'b100 :
                (lat == 6'b001010) ? 3'b101 : 3'b000;
      end
      4'd12: rw = 1'b1;
      default: ;
    endcase
    return {s, aluop, srcb, pcs, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic drive_and_check(input logic [5:0] op, input logic mr,
                                 input logic [3:0] s, input string tag);
    sb_t e;
    u_if.Opcode   = op;
    u_if.MemReady = mr;
    sb_q.push_back('{tag, (rst_n ? model(s, tb_lat, op, mr) : 22'd0)});
    if (s == 4'd2) tb_lat = op;
    #1;
    e = sb_q.pop_front();
    check_eq(e.tag, w_obs, e.v);
  endtask

  task automatic step(input logic [5:0] op, input logic mr, input logic [3:0] s,
                      input string tag);
    @(negedge clk);
    drive_and_check(op, mr, s, tag);
  endtask

  task automatic run_imm(input logic [5:0] op, input string tag);
    step(rnd_op(), 1'b1, 4'd1,  {tag, "_fetch"});
    step(op,       1'b1, 4'd2,  {tag, "_dec"});
    step(rnd_op(), 1'b1, 4'd11, {tag, "_iexec"});
    step(rnd_op(), 1'b1, 4'd12, {tag, "_iwb"});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    tb_lat   = 6'd0;
    rst_n    = 1'b0;
    u_if.Opcode   = 6'd0;
    u_if.MemReady = 1'b0;

    @(negedge clk);
    drive_and_check(rnd_op(), 1'b1, 4'd0, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive_and_check(rnd_op(), 1'b1, 4'd0, "idle");

    // R-type: 0,1,2,7,8,1
    step(rnd_op(), 1'b1, 4'd1, "rt_fetch");
    step(6'b000000, 1'b1, 4'd2, "rt_dec");
    step(rnd_op(), 1'b1, 4'd7, "rt_exec");
    step(rnd_op(), 1'b1, 4'd8, "rt_rwb");

    // lw with one FETCH stall and two MEMRD stalls
    step(rnd_op(), 1'b0, 4'd1, "lw_fwait");
    step(rnd_op(), 1'b1, 4'd1, "lw_fetch");
    step(6'b100011, 1'b1, 4'd2, "lw_dec");
    step(rnd_op(), 1'b1, 4'd3, "lw_madr");
    step(rnd_op(), 1'b0, 4'd4, "lw_rd0");
    step(rnd_op(), 1'b0, 4'd4, "lw_rd1");
    step(rnd_op(), 1'b1, 4'd4, "lw_rd2");
    step(rnd_op(), 1'b1, 4'd5, "lw_wb");

    // ori, with a beq opcode presented during IEXEC
    step(rnd_op(),  1'b1, 4'd1,  "ori_fetch");
    step(6'b001101, 1'b1, 4'd2,  "ori_dec");
    step(6'b000100, 1'b1, 4'd11, "ori_iexec");
    step(rnd_op(),  1'b1, 4'd12, "ori_iwb");

    run_imm(6'b001000, "addi");
    run_imm(6'b001100, "andi");
    run_imm(6'b001010, "slti");

    step(rnd_op(),  1'b1, 4'd1,  "beq_fetch");
    step(6'b000100, 1'b1, 4'd2,  "beq_dec");
    step(rnd_op(),  1'b1, 4'd9,  "beq_br");
    step(rnd_op(),  1'b1, 4'd1,  "j_fetch");
    step(6'b000010, 1'b1, 4'd2,  "j_dec");
    step(rnd_op(),  1'b1, 4'd10, "j_jump");

    step(rnd_op(),  1'b1, 4'd1, "ill_fetch");
    step(6'b111111, 1'b1, 4'd2, "ill_dec");
    step(rnd_op(),  1'b1, 4'd1, "ill_fetch2");
    step(6'b000001, 1'b1, 4'd2, "ill2_dec");

    // sw with two MEMWR stalls
    step(rnd_op(),  1'b1, 4'd1, "sw_fetch");
    step(6'b101011, 1'b1, 4'd2, "sw_dec");
    step(rnd_op(),  1'b1, 4'd3, "sw_madr");
    step(rnd_op(),  1'b0, 4'd6, "sw_wr0");
    step(rnd_op(),  1'b0, 4'd6, "sw_wr1");
    step(rnd_op(),  1'b1, 4'd6, "sw_wr2");

    // second sw aborted by asynchronous reset during a MEMWR stall
    step(rnd_op(),  1'b1, 4'd1, "sw2_fetch");
    step(6'b101011, 1'b1, 4'd2, "sw2_dec");
    step(rnd_op(),  1'b1, 4'd3, "sw2_madr");
    step(rnd_op(),  1'b0, 4'd6, "sw2_wr0");
    #2;
    rst_n = 1'b0;
    drive_and_check(rnd_op(), 1'b1, 4'd0, "rst_async");
    @(negedge clk);
    drive_and_check(rnd_op(), 1'b1, 4'd0, "rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    tb_lat = 6'd0;
    drive_and_check(rnd_op(), 1'b1, 4'd0, "rel_idle");
    step(rnd_op(),  1'b1, 4'd1,  "rel_fetch");
    step(6'b000010, 1'b1, 4'd2,  "rel_j_dec");
    step(rnd_op(),  1'b1, 4'd10, "rel_j_jump");
    step(rnd_op(),  1'b1, 4'd1,  "rel_fetch2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
